uart_transmitter: RTL and testbench
===================================

# uart_transmitter

8-N-1 UART serial transmitter. On a start request it latches one byte and shifts it out on a single line as a 10-bit frame: start bit 0, eight data bits LSB first, stop bit 1. It sits between a byte-wide parallel producer and the serial TX pin. An internal bit counter exposes frame completion.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit. Must be ≥1. A baud divider counts 0..CLKS_PER_BIT-1.
- `i_clk` in 1: single clock. All state updates on the rising edge.
- `i_reset` in 1: reset, asynchronous, active-high.
- `i_Txstart` in 1: transmit request, level-sensitive, sampled on the rising edge.
- `i_datain` in 8: byte to send. Latched only when a frame starts.
- `o_Txdataout` out 1: serial line, registered. Idles high.

## Operation
- States:
  - IDLE: line = 1, count = 0.
  - SEND: covers the start, data and stop bits.
  - DONE: line = 1, count = 10.
- Bit counter: internal 4-bit register `count`, in instance `COUNTER_t`, so it is hierarchically visible as `COUNTER_t.count`.
- IDLE → SEND when `i_Txstart` = 1 at a rising edge.
  - Same edge: latch `i_datain` into the shift register, drive line 0 (start bit), count = 0, baud divider = 0.
- SEND: at each bit boundary (divider wraps), count increments and the line is driven as follows.
  - count 1..8: data bit d[count-1], LSB first.
  - count 9: stop bit 1.
  - count 10: enter DONE, line stays 1.
- DONE: holds count = 10 and line = 1 while `i_Txstart` = 1.
  - When `i_Txstart` = 0 at a rising edge: go to IDLE, count = 0.
  - Holding `i_Txstart` high never retransmits; the request must drop before the next frame is accepted.
- Changes to `i_datain` or `i_Txstart` during SEND are ignored. The frame always completes.
- Reset (any time, including mid-frame), asynchronously:
  - state = IDLE, `o_Txdataout` = 1, count = 0, divider = 0, shift register = 0.
  - A partially sent frame is abandoned.
- Counter widths:
  - count is 4 bits and never exceeds 10.
  - The divider is wide enough for CLKS_PER_BIT-1. The team's bench uses CLKS_PER_BIT ≤ 65535, so a 16-bit divider suffices.

## Timing
- Request sampled at edge E0 (IDLE, `i_Txstart` = 1):
  - E0: line goes to 0.
  - E0 + k·CLKS_PER_BIT for k = 1..8: line = d[k-1].
  - E0 + 9·CLKS_PER_BIT: line = 1 (stop bit).
  - E0 + 10·CLKS_PER_BIT: count = 10, DONE.
- Each bit is held exactly CLKS_PER_BIT cycles. Frame length is 10·CLKS_PER_BIT cycles.
- Latency from request to the start bit on the line: 0 cycles after the sampling edge (the output register updates on E0).
- Handshake: the producer holds `i_Txstart` high until it sees count = 10, then lowers it.
  - Earliest next frame: the first rising edge after the one that returns to IDLE, with `i_Txstart` high again.
  - Minimum gap between frames: 2 cycles of idle-high line.
- `i_Txstart` dropping before count = 10 has no effect on the frame in progress. The block then returns to IDLE directly from DONE on the next edge.

## Test plan
- Reset: assert `i_reset` with the clock running.
  - Immediately `o_Txdataout` = 1 and count = 0, without waiting for an edge.
  - Both remain so with `i_Txstart` = 0.
- Single frame, `i_datain` = 0x58, CLKS_PER_BIT = 1: raise `i_Txstart`.
  - Line sequence: 0 | 0,0,0,1,1,0,1,0 | 1.
  - Then count = 10 and line = 1.
  - Lowering `i_Txstart` returns count to 0.
- Three back-to-back 0x58 frames, each requested about 150 ns after the previous completion (10 ns clock): three identical waveforms, with the line high between frames.
- Held request: keep `i_Txstart` = 1 for 30 cycles after count = 10.
  - No second start bit; line stays 1 and count stays 10.
- Mid-frame disturbance: change `i_datain` from 0xA5 to 0xFF and pulse `i_reset` after data bit 3 (separate runs).
  - Data change: the frame still carries 0xA5 (line 0 | 1,0,1,0,0,1,0,1 | 1).
  - Reset: line is immediately 1 and count = 0; a new request then sends a full fresh frame.
- CLKS_PER_BIT = 4, `i_datain` = 0x01: start bit lasts 4 cycles, d0 = 1 for 4 cycles, d1..d7 = 0 for 28 cycles, stop bit 4 cycles. count = 10 at E0 + 40.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: parallel request/data and serial line bundle for the UART transmitter
interface uart_transmitter_if;
  logic       i_Txstart;
  logic [7:0] i_datain;
  logic       o_Txdataout;
  modport master (output i_Txstart, output i_datain, input o_Txdataout);
  modport slave (input i_Txstart, input i_datain, output o_Txdataout);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-N-1 serial transmitter with a hierarchically visible bit counter
module uart_transmitter_counter (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_count
);
  logic [3:0] count;
  // frame bit position: cleared on frame start/return to idle, bumped at each bit boundary
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) count <= 4'd0;
    else if (i_clr) count <= 4'd0;
    else if (i_inc) count <= count + 4'd1;
  assign o_count = count;
endmodule

module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input logic                i_clk,
  input logic                i_reset,
  uart_transmitter_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  logic [1:0]  state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        clr, inc;
  logic [3:0]  count, count_nx;
  uart_transmitter_counter COUNTER_t (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (clr),
    .i_inc   (inc),
    .o_count (count)
  );
  assign count_nx = count + 4'd1;
  // next-state: start bit goes out on the accepting edge; data shifts LSB first at each divider wrap
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    clr     = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.i_Txstart) begin
          state_d = SEND;
          sh_d    = bus.i_datain;
          tx_d    = 1'b0;
          div_d   = 16'd0;
          clr     = 1'b1;
        end
      end
      SEND: begin
        if (div_q == LAST) begin
          div_d = 16'd0;
          inc   = 1'b1;
          tx_d  = count_nx <= 4'd8 ? sh_q[0] : 1'b1;
          sh_d  = count_nx <= 4'd8 ? {1'b0, sh_q[7:1]} : sh_q;
          state_d = count_nx == 4'd10 ? DONE : SEND;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      DONE: begin
        tx_d = 1'b1;
        if (!bus.i_Txstart) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        clr     = 1'b1;
      end
    endcase
  end
  // state registers; reset abandons any frame and parks the line high
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q <= IDLE;
      div_q   <= 16'd0;
      sh_q    <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  assign bus.o_Txdataout = tx_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench for the 8-N-1 transmitter at 1 and 4 clocks per bit
module tb_uart_transmitter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  uart_transmitter_if b1 ();
  uart_transmitter_if b4 ();
  uart_transmitter #(.CLKS_PER_BIT(1)) dut1 (.i_clk(clk), .i_reset(rst), .bus(b1));
  uart_transmitter #(.CLKS_PER_BIT(4)) dut4 (.i_clk(clk), .i_reset(rst), .bus(b4));
  typedef struct packed {
    logic       l;
    logic [3:0] c;
  } exp_t;
  exp_t q1[$];
  exp_t q4[$];
  exp_t m1, m4;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic push(input bit sel, input logic l, input logic [3:0] c, input int n);
    exp_t e;
    e.l = l;
    e.c = c;
    for (int i = 0; i < n; i++)
      if (sel) q4.push_back(e);
      else q1.push_back(e);
  endtask
  always @(negedge clk)
    if (q1.size() > 0) begin
      m1 = q1.pop_front();
      chk("line_cpb1", {3'b0, b1.o_Txdataout}, {3'b0, m1.l});
      chk("count_cpb1", dut1.COUNTER_t.count, m1.c);
    end
  always @(negedge clk)
    if (q4.size() > 0) begin
      m4 = q4.pop_front();
      chk("line_cpb4", {3'b0, b4.o_Txdataout}, {3'b0, m4.l});
      chk("count_cpb4", dut4.COUNTER_t.count, m4.c);
    end
  task automatic set_req(input bit sel, input logic s, input logic [7:0] d);
    if (sel) begin
      b4.i_Txstart = s;
      b4.i_datain  = d;
    end else begin
      b1.i_Txstart = s;
      b1.i_datain  = d;
    end
  endtask
  task automatic frame(input bit sel, input logic [7:0] d, input int hold, input int gap, input bit chg);
    int cpb;
    cpb = sel ? 4 : 1;
    push(sel, 1'b0, 4'd0, cpb);
    for (int k = 1; k <= 8; k++) push(sel, d[k-1], 4'(k), cpb);
    push(sel, 1'b1, 4'd9, cpb);
    push(sel, 1'b1, 4'd10, 1 + hold);
    set_req(sel, 1'b1, d);
    repeat (5 * cpb) @(negedge clk);
    #1;
    if (chg) set_req(sel, 1'b1, 8'hFF);
    repeat (5 * cpb + 1 + hold) @(negedge clk);
    #1;
    push(sel, 1'b1, 4'd0, gap);
    set_req(sel, 1'b0, chg ? 8'hFF : d);
    repeat (gap) @(negedge clk);
    #1;
  endtask
  initial begin
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_line", {3'b0, b1.o_Txdataout}, 4'd1);
    chk("rst_async_count", dut1.COUNTER_t.count, 4'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hold_line", {3'b0, b1.o_Txdataout}, 4'd1);
    chk("rst_hold_count", dut1.COUNTER_t.count, 4'd0);
    chk("rst_hold_line4", {3'b0, b4.o_Txdataout}, 4'd1);
    rst = 1'b0;
    frame(0, 8'h58, 0, 2, 0);
    frame(0, 8'h58, 0, 15, 0);
    frame(0, 8'h58, 0, 15, 0);
    frame(0, 8'h58, 0, 15, 0);
    frame(0, 8'h58, 30, 2, 0);
    frame(0, 8'hA5, 0, 2, 1);
    push(0, 1'b0, 4'd0, 1);
    push(0, 1'b1, 4'd1, 1);
    push(0, 1'b0, 4'd2, 1);
    push(0, 1'b1, 4'd3, 1);
    push(0, 1'b0, 4'd4, 1);
    set_req(0, 1'b1, 8'hA5);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    set_req(0, 1'b0, 8'hA5);
    #1;
    chk("midrst_line", {3'b0, b1.o_Txdataout}, 4'd1);
    chk("midrst_count", dut1.COUNTER_t.count, 4'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    frame(0, 8'h3C, 0, 2, 0);
    frame(1, 8'h01, 0, 2, 0);
    for (int i = 0; i < 100 && (q1.size() > 0 || q4.size() > 0); i++) @(negedge clk);
    chk("drain", 4'((q1.size() + q4.size()) > 0 ? 1 : 0), 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
